// File: rtl/mul4_fitness_scorer_if.sv
// mul4_fitness_scorer_if: start/done handshake, operand slices out,
// candidate product slices in, and the scoring results.
interface mul4_fitness_scorer_if #(
    parameter int SCORE_W = 7
);
    logic               start;
    logic               busy;
    logic               done;
    logic [15:0]        a1;
    logic [15:0]        a0;
    logic [15:0]        b1;
    logic [15:0]        b0;
    logic [15:0]        y3;
    logic [15:0]        y2;
    logic [15:0]        y1;
    logic [15:0]        y0;
    logic [SCORE_W-1:0] score;
    logic               perfect;
    logic [3:0]         first_fail;
    logic               fail_valid;

    modport master (
        output start, y3, y2, y1, y0,
        input  busy, done, a1, a0, b1, b0,
        input  score, perfect, first_fail, fail_valid
    );

    modport slave (
        input  start, y3, y2, y1, y0,
        output busy, done, a1, a0, b1, b0,
        output score, perfect, first_fail, fail_valid
    );
endinterface

// File: rtl/mul4_fitness_scorer.sv
// mul4_fitness_scorer: drives exhaustive 2x2 operand slices into a candidate,
// captures its product slices and scores them lane by lane against golden.
module mul4_fitness_scorer #(
    parameter int LANES   = 16,
    parameter int SETTLE  = 2,
    parameter int SCORE_W = 7
) (
    input logic                  clk,
    input logic                  rst_n,
    mul4_fitness_scorer_if.slave bus
);
    localparam logic [15:0] A1_V = 16'hFF00;
    localparam logic [15:0] A0_V = 16'hF0F0;
    localparam logic [15:0] B1_V = 16'hCCCC;
    localparam logic [15:0] B0_V = 16'hAAAA;
    localparam logic [15:0] P3_V = 16'h8000;
    localparam logic [15:0] P2_V = 16'h4C00;
    localparam logic [15:0] P1_V = 16'h6AC0;
    localparam logic [15:0] P0_V = 16'hA0A0;

    localparam logic [3:0]         LAST_LANE = 4'(LANES - 1);
    localparam logic [3:0]         CNT_LOAD  = 4'(SETTLE - 1);
    localparam logic [SCORE_W-1:0] MAX_SCORE = SCORE_W'(4 * LANES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SCAN,
        S_DONE
    } state_t;

    state_t             r_state;
    logic               r_drv;
    logic [3:0]         r_cnt;
    logic [3:0]         r_lane;
    logic [15:0]        r_y3;
    logic [15:0]        r_y2;
    logic [15:0]        r_y1;
    logic [15:0]        r_y0;
    logic               r_busy;
    logic               r_done;
    logic [SCORE_W-1:0] r_score;
    logic               r_perfect;
    logic [3:0]         r_first_fail;
    logic               r_fail_valid;

    logic [15:0]        w_p3;
    logic [15:0]        w_p2;
    logic [15:0]        w_p1;
    logic [15:0]        w_p0;
    logic [3:0]         w_got;
    logic [3:0]         w_gold;
    logic [3:0]         w_diff;
    logic [2:0]         w_err;
    logic [2:0]         w_m;
    logic [SCORE_W-1:0] w_score_nx;

    assign w_p3 = P3_V;
    assign w_p2 = P2_V;
    assign w_p1 = P1_V;
    assign w_p0 = P0_V;

    // Per-lane match count of the captured product against golden
    always_comb begin
        w_got      = {r_y3[r_lane], r_y2[r_lane], r_y1[r_lane], r_y0[r_lane]};
        w_gold     = {w_p3[r_lane], w_p2[r_lane], w_p1[r_lane], w_p0[r_lane]};
        w_diff     = w_got ^ w_gold;
        w_err      = {2'b00, w_diff[0]} + {2'b00, w_diff[1]}
                   + {2'b00, w_diff[2]} + {2'b00, w_diff[3]};
        w_m        = 3'd4 - w_err;
        w_score_nx = r_score + SCORE_W'(w_m);
    end

    // Operands sit at zero unless an evaluation is actively driving them
    assign bus.a1 = r_drv ? A1_V : 16'h0000;
    assign bus.a0 = r_drv ? A0_V : 16'h0000;
    assign bus.b1 = r_drv ? B1_V : 16'h0000;
    assign bus.b0 = r_drv ? B0_V : 16'h0000;

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.score      = r_score;
    assign bus.perfect    = r_perfect;
    assign bus.first_fail = r_first_fail;
    assign bus.fail_valid = r_fail_valid;

    // Evaluation FSM: accept, drive, settle, capture, scan, report
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_drv        <= 1'b0;
            r_cnt        <= 4'd0;
            r_lane       <= 4'd0;
            r_y3         <= 16'h0000;
            r_y2         <= 16'h0000;
            r_y1         <= 16'h0000;
            r_y0         <= 16'h0000;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_score      <= '0;
            r_perfect    <= 1'b0;
            r_first_fail <= 4'd0;
            r_fail_valid <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state      <= S_SETTLE;
                        r_busy       <= 1'b1;
                        r_cnt        <= CNT_LOAD;
                        r_lane       <= 4'd0;
                        r_score      <= '0;
                        r_perfect    <= 1'b0;
                        r_first_fail <= 4'd0;
                        r_fail_valid <= 1'b0;
                    end
                end
                S_SETTLE: begin
                    if (!r_drv) begin
                        r_drv <= 1'b1;
                    end else if (r_cnt == 4'd0) begin
                        r_y3    <= bus.y3;
                        r_y2    <= bus.y2;
                        r_y1    <= bus.y1;
                        r_y0    <= bus.y0;
                        r_lane  <= 4'd0;
                        r_state <= S_SCAN;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_SCAN: begin
                    r_score <= w_score_nx;
                    if (w_m != 3'd4 && !r_fail_valid) begin
                        r_first_fail <= r_lane;
                        r_fail_valid <= 1'b1;
                    end
                    if (r_lane == LAST_LANE) begin
                        r_state   <= S_DONE;
                        r_done    <= 1'b1;
                        r_perfect <= (w_score_nx == MAX_SCORE);
                    end else begin
                        r_lane <= r_lane + 4'd1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_drv   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul4_fitness_scorer.sv
// tb_mul4_fitness_scorer: table of candidate behaviours with a scoreboard,
// plus hand sequences for re-pulsed start and reset during the scan.
module tb_mul4_fitness_scorer;
    logic clk;
    logic rst_n;

    mul4_fitness_scorer_if #(.SCORE_W(7)) if2 ();
    mul4_fitness_scorer_if #(.SCORE_W(7)) if4 ();

    mul4_fitness_scorer #(.LANES(16), .SETTLE(2), .SCORE_W(7)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if2.slave)
    );

    mul4_fitness_scorer #(.LANES(16), .SETTLE(4), .SCORE_W(7)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if4.slave)
    );

    typedef struct {
        int         mode;
        logic [6:0] score;
        logic       perfect;
        logic [3:0] ff;
        logic       fv;
    } exp_t;

    int   n_cmp;
    int   n_fail;
    int   cand_mode;
    exp_t sb[$];
    exp_t vec[4];

    logic [63:0] pipe2_s1, pipe2_s2, pipe2_s3;
    logic [63:0] pipe4_s1, pipe4_s2, pipe4_s3;
    logic [63:0] ideal2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference multiplier: product slices {y3,y2,y1,y0} from operand slices
    function automatic logic [63:0] mulvec(input logic [15:0] a1, a0, b1, b0);
        logic [15:0] p3, p2, p1, p0;
        logic [3:0]  p;
        for (int i = 0; i < 16; i++) begin
            p = {2'b00, a1[i], a0[i]} * {2'b00, b1[i], b0[i]};
            p3[i] = p[3];
            p2[i] = p[2];
            p1[i] = p[1];
            p0[i] = p[0];
        end
        return {p3, p2, p1, p0};
    endfunction

    assign ideal2 = mulvec(if2.a1, if2.a0, if2.b1, if2.b0);

    // 3-cycle pipelined candidates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe2_s1 <= '0; pipe2_s2 <= '0; pipe2_s3 <= '0;
            pipe4_s1 <= '0; pipe4_s2 <= '0; pipe4_s3 <= '0;
        end else begin
            pipe2_s1 <= ideal2;
            pipe2_s2 <= pipe2_s1;
            pipe2_s3 <= pipe2_s2;
            pipe4_s1 <= mulvec(if4.a1, if4.a0, if4.b1, if4.b0);
            pipe4_s2 <= pipe4_s1;
            pipe4_s3 <= pipe4_s2;
        end
    end

    // Candidate behaviour on the SETTLE=2 instance
    always_comb begin
        {if2.y3, if2.y2, if2.y1, if2.y0} = ideal2;
        case (cand_mode)
            1: {if2.y3, if2.y2, if2.y1, if2.y0} = '0;
            2: if2.y3 = 16'hFFFF;
            3: {if2.y3, if2.y2, if2.y1, if2.y0} = pipe2_s3;
            default: ;
        endcase
    end

    assign {if4.y3, if4.y2, if4.y1, if4.y0} = pipe4_s3;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic set_start(input int sel, input logic v);
        if (sel == 0) if2.start = v;
        else          if4.start = v;
    endtask

    function automatic logic get_done(input int sel);
        return (sel == 0) ? if2.done : if4.done;
    endfunction

    function automatic logic get_busy(input int sel);
        return (sel == 0) ? if2.busy : if4.busy;
    endfunction

    task automatic run(input int sel, input exp_t e, input int exp_lat, input bit repulse);
        int   n;
        int   glitch;
        int   quiet;
        bit   got;
        exp_t x;
        logic [6:0] sc;
        sb.push_back(e);
        cand_mode = e.mode;
        n = 0; glitch = 0; got = 0;
        set_start(sel, 1'b1);
        while (!got && n < 60) begin
            @(negedge clk);
            n++;
            set_start(sel, repulse && (n == 5 || n == 19 || n == 20));
            if (sel == 0 && n == 1) chk("a1_not_yet", {16'h0, if2.a1}, 32'h0);
            if (sel == 0 && n == 3) begin
                chk("a1_drive", {16'h0, if2.a1}, 32'hFF00);
                chk("a0_drive", {16'h0, if2.a0}, 32'hF0F0);
                chk("b1_drive", {16'h0, if2.b1}, 32'hCCCC);
                chk("b0_drive", {16'h0, if2.b0}, 32'hAAAA);
            end
            if (get_done(sel)) got = 1;
            else if (get_busy(sel) !== 1'b1) glitch++;
        end
        if (!got) begin
            n_cmp++; n_fail++;
            $display("FAIL done_timeout: got no done want done at %0d", exp_lat);
            if (sb.size() > 0) void'(sb.pop_front());
        end else begin
            chk("latency", n, exp_lat);
            chk("busy_at_done", {31'h0, get_busy(sel)}, 32'h1);
            if (sb.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL sb_empty: got done want no done");
            end else begin
                x = sb.pop_front();
                if (sel == 0) begin
                    sc = if2.score;
                    chk("perfect", {31'h0, if2.perfect}, {31'h0, x.perfect});
                    chk("first_fail", {28'h0, if2.first_fail}, {28'h0, x.ff});
                    chk("fail_valid", {31'h0, if2.fail_valid}, {31'h0, x.fv});
                end else begin
                    sc = if4.score;
                    chk("perfect4", {31'h0, if4.perfect}, {31'h0, x.perfect});
                    chk("first_fail4", {28'h0, if4.first_fail}, {28'h0, x.ff});
                    chk("fail_valid4", {31'h0, if4.fail_valid}, {31'h0, x.fv});
                end
                chk("score", {25'h0, sc}, {25'h0, x.score});
            end
        end
        chk("busy_steady", glitch, 0);
        @(negedge clk);
        set_start(sel, 1'b0);
        chk("done_pulse", {31'h0, get_done(sel)}, 32'h0);
        chk("busy_drop", {31'h0, get_busy(sel)}, 32'h0);
        quiet = 0;
        repeat (3) begin
            @(negedge clk);
            if (get_done(sel) || get_busy(sel)) quiet++;
        end
        chk("idle_quiet", quiet, 0);
        sc = (sel == 0) ? if2.score : if4.score;
        chk("score_hold", {25'h0, sc}, {25'h0, e.score});
        if (sel == 0) chk("a1_idle", {16'h0, if2.a1}, 32'h0);
    endtask

    initial begin
        int   n;
        int   spur;
        exp_t e;
        n_cmp = 0; n_fail = 0; cand_mode = 0;
        if2.start = 1'b0;
        if4.start = 1'b0;
        rst_n = 1'b0;

        vec[0] = '{mode: 0, score: 7'd64, perfect: 1'b1, ff: 4'd0, fv: 1'b0};
        vec[1] = '{mode: 1, score: 7'd50, perfect: 1'b0, ff: 4'd5, fv: 1'b1};
        vec[2] = '{mode: 2, score: 7'd49, perfect: 1'b0, ff: 4'd0, fv: 1'b1};
        vec[3] = '{mode: 3, score: 7'd50, perfect: 1'b0, ff: 4'd5, fv: 1'b1};

        repeat (2) @(negedge clk);
        chk("rst_busy", {31'h0, if2.busy}, 32'h0);
        chk("rst_done", {31'h0, if2.done}, 32'h0);
        chk("rst_score", {25'h0, if2.score}, 32'h0);
        chk("rst_perfect", {31'h0, if2.perfect}, 32'h0);
        chk("rst_fv", {31'h0, if2.fail_valid}, 32'h0);
        chk("rst_ops", {if2.a1 | if2.a0, if2.b1 | if2.b0}, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 4; i++) run(0, vec[i], 20, 1'b0);

        e = '{mode: 0, score: 7'd64, perfect: 1'b1, ff: 4'd0, fv: 1'b0};
        run(1, e, 22, 1'b0);

        run(0, vec[1], 20, 1'b1);
        run(0, vec[0], 20, 1'b1);

        cand_mode = 0;
        set_start(0, 1'b1);
        n = 0;
        while (n < 11) begin
            @(negedge clk);
            n++;
            set_start(0, 1'b0);
        end
        chk("pre_abort_score", {25'h0, if2.score}, 32'd28);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'h0, if2.busy}, 32'h0);
        chk("abort_score", {25'h0, if2.score}, 32'h0);
        chk("abort_ops", {if2.a1 | if2.a0, if2.b1 | if2.b0}, 32'h0);
        chk("abort_ff", {27'h0, if2.fail_valid, if2.first_fail}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        spur = 0;
        repeat (25) begin
            @(negedge clk);
            if (if2.done || if2.busy) spur++;
        end
        chk("abort_no_done", spur, 0);

        run(0, vec[2], 20, 1'b0);
        run(0, vec[0], 20, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
